// File: rtl/dp_pkg.sv
// Shared types and default sizing for the datapath result checker.
package dp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_CNTW      = 8;

endpackage

// File: rtl/dp_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module dp_sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {width{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dp_result_checker.sv
// Accepts expected-result vectors, waits for the datapath to settle, then
// compares its output and keeps pass/fail statistics for the run.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | ready for the next vector
//   SETTLE  | counting down settle cycles before sampling
//   CHECK   | compare dut_out against the latched expectation
//   DONE    | last vector checked; frozen until rst
module dp_result_checker
    import dp_pkg::*;
#(
    parameter int DATAWIDTH     = DEF_DATAWIDTH,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNTW          = DEF_CNTW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [DATAWIDTH-1:0] vec_exp,
    input  logic                 vec_last,
    input  logic [DATAWIDTH-1:0] dut_out,
    output logic [CNTW-1:0]      pass_cnt,
    output logic [CNTW-1:0]      fail_cnt,
    output logic [CNTW-1:0]      first_fail_idx,
    output logic                 first_fail_vld,
    output logic                 mismatch,
    output logic                 done
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t                state;
    logic [3:0]            settle_cnt;
    logic [DATAWIDTH-1:0]  exp_q;
    logic                  last_q;
    logic [CNTW-1:0]       vec_idx;
    logic                  in_check;
    logic                  is_match;
    logic                  pass_inc;
    logic                  fail_inc;

    // Gated by rst so nothing looks acceptable while reset is held.
    assign vec_ready = (state == ST_IDLE) && !rst;
    assign in_check  = (state == ST_CHECK);
    assign is_match  = (dut_out == exp_q);
    assign pass_inc  = in_check && is_match;
    assign fail_inc  = in_check && !is_match;

    dp_sat_counter #(.width(CNTW)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pass_inc),
        .count (pass_cnt)
    );

    dp_sat_counter #(.width(CNTW)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fail_inc),
        .count (fail_cnt)
    );

    dp_sat_counter #(.width(CNTW)) u_vec_idx (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_check),
        .count (vec_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            exp_q          <= '0;
            last_q         <= 1'b0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            mismatch       <= 1'b0;
            done           <= 1'b0;
        end else begin
            mismatch <= fail_inc;
            if (fail_inc && !first_fail_vld) begin
                first_fail_idx <= vec_idx;
                first_fail_vld <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (vec_valid && vec_ready) begin
                        exp_q      <= vec_exp;
                        last_q     <= vec_last;
                        settle_cnt <= SETTLE_INIT;
                        state      <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (last_q) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_result_checker.sv
// Directed bench: default checker, a 2-bit-counter variant and a zero-settle variant.
module tb_dp_result_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: defaults (DATAWIDTH 8, SETTLE 2, CNTW 8)
    logic       a_valid = 1'b0, a_ready, a_last = 1'b0, a_ffv, a_mis, a_done;
    logic [7:0] a_exp = '0, a_out = '0, a_pass, a_fail, a_ffi;

    // Instance B: CNTW 2
    logic       b_valid = 1'b0, b_ready, b_last = 1'b0, b_ffv, b_mis, b_done;
    logic [7:0] b_exp = '0, b_out = '0;
    logic [1:0] b_pass, b_fail, b_ffi;

    // Instance C: SETTLE_CYCLES 0
    logic       c_valid = 1'b0, c_ready, c_last = 1'b0, c_ffv, c_mis, c_done;
    logic [7:0] c_exp = '0, c_out = '0, c_pass, c_fail, c_ffi;

    dp_result_checker u_a (
        .clk(clk), .rst(rst), .vec_valid(a_valid), .vec_ready(a_ready), .vec_exp(a_exp),
        .vec_last(a_last), .dut_out(a_out), .pass_cnt(a_pass), .fail_cnt(a_fail),
        .first_fail_idx(a_ffi), .first_fail_vld(a_ffv), .mismatch(a_mis), .done(a_done)
    );

    dp_result_checker #(.CNTW(2)) u_b (
        .clk(clk), .rst(rst), .vec_valid(b_valid), .vec_ready(b_ready), .vec_exp(b_exp),
        .vec_last(b_last), .dut_out(b_out), .pass_cnt(b_pass), .fail_cnt(b_fail),
        .first_fail_idx(b_ffi), .first_fail_vld(b_ffv), .mismatch(b_mis), .done(b_done)
    );

    dp_result_checker #(.SETTLE_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .vec_valid(c_valid), .vec_ready(c_ready), .vec_exp(c_exp),
        .vec_last(c_last), .dut_out(c_out), .pass_cnt(c_pass), .fail_cnt(c_fail),
        .first_fail_idx(c_ffi), .first_fail_vld(c_ffv), .mismatch(c_mis), .done(c_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("ready_in_rst", 32'(a_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(a_ready), 32'd1);
    endtask

    // Dut_out is wrong on every cycle except the one just before the compare
    // edge (acceptance + 3), so an off-by-one sample point shows up.
    task automatic send_a(input logic [7:0] e, input logic [7:0] o, input logic l,
                          output int pulses, output int at);
        pulses  = 0;
        at      = 0;
        a_valid = 1'b1;
        a_exp   = e;
        a_last  = l;
        a_out   = ~o;
        step();
        a_valid = 1'b0;
        a_exp   = ~e;
        a_last  = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (a_mis) begin
                pulses++;
                at = k;
            end
            a_out = (k == 2) ? o : ~o;
        end
    endtask

    task automatic send_b(input logic [7:0] e, input logic [7:0] o);
        b_valid = 1'b1;
        b_exp   = e;
        b_out   = o;
        step();
        b_valid = 1'b0;
        repeat (4) step();
    endtask

    int pulses, at;

    initial begin
        // Reset state
        do_reset();
        check("rst_pass", 32'(a_pass), 32'd0);
        check("rst_fail", 32'(a_fail), 32'd0);
        check("rst_ffv", 32'(a_ffv), 32'd0);
        check("rst_mis", 32'(a_mis), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);

        // ADD 1+2 = 3, matching
        send_a(8'd3, 8'd3, 1'b0, pulses, at);
        check("add_pass", 32'(a_pass), 32'd1);
        check("add_fail", 32'(a_fail), 32'd0);
        check("add_pulses", 32'(pulses), 32'd0);

        // DIV 6/3 faulty: expected 2, got 1, as vector 0
        do_reset();
        send_a(8'd2, 8'd1, 1'b0, pulses, at);
        check("div_fail", 32'(a_fail), 32'd1);
        check("div_pass", 32'(a_pass), 32'd0);
        check("div_pulses", 32'(pulses), 32'd1);
        check("div_pulse_at", 32'(at), 32'd3);
        check("div_ffi", 32'(a_ffi), 32'd0);
        check("div_ffv", 32'(a_ffv), 32'd1);

        // Four-vector run, vectors 1 and 3 mismatch, last on vector 3
        do_reset();
        send_a(8'h05, 8'h05, 1'b0, pulses, at);
        check("run_v0_done", 32'(a_done), 32'd0);
        send_a(8'h07, 8'h06, 1'b0, pulses, at);
        check("run_v1_pulses", 32'(pulses), 32'd1);
        send_a(8'h09, 8'h09, 1'b0, pulses, at);
        send_a(8'hAA, 8'h55, 1'b1, pulses, at);
        check("run_pass", 32'(a_pass), 32'd2);
        check("run_fail", 32'(a_fail), 32'd2);
        check("run_ffi", 32'(a_ffi), 32'd1);
        check("run_done", 32'(a_done), 32'd1);
        check("run_ready", 32'(a_ready), 32'd0);
        a_valid = 1'b1;
        a_exp   = 8'h11;
        a_out   = 8'h11;
        repeat (6) step();
        a_valid = 1'b0;
        check("done_ignore_pass", 32'(a_pass), 32'd2);
        check("done_hold", 32'(a_done), 32'd1);
        check("done_ready", 32'(a_ready), 32'd0);

        // Reset during SETTLE discards the vector
        do_reset();
        a_valid = 1'b1;
        a_exp   = 8'h04;
        a_out   = 8'h09;
        a_last  = 1'b0;
        step();
        a_valid = 1'b0;
        step();
        check("settle_state", 32'(a_ready), 32'd0);
        do_reset();
        repeat (4) step();
        check("discard_fail", 32'(a_fail), 32'd0);
        check("discard_pass", 32'(a_pass), 32'd0);
        check("discard_ffv", 32'(a_ffv), 32'd0);
        check("discard_ready", 32'(a_ready), 32'd1);
        send_a(8'h01, 8'h02, 1'b0, pulses, at);
        check("discard_next_idx", 32'(a_ffi), 32'd0);
        check("discard_next_fail", 32'(a_fail), 32'd1);

        // CNTW=2 saturation: 5 matches then a mismatch at saturated index
        do_reset();
        for (int i = 0; i < 5; i++) send_b(8'(i + 1), 8'(i + 1));
        check("sat_pass", 32'(b_pass), 32'd3);
        check("sat_fail0", 32'(b_fail), 32'd0);
        send_b(8'h30, 8'h31);
        check("sat_fail1", 32'(b_fail), 32'd1);
        check("sat_ffi", 32'(b_ffi), 32'd3);
        check("sat_ffv", 32'(b_ffv), 32'd1);
        check("sat_pass_hold", 32'(b_pass), 32'd3);

        // SETTLE_CYCLES=0 with vec_valid held: accept every 2 cycles,
        // dut_out matches only on the edge after each acceptance.
        do_reset();
        c_valid = 1'b1;
        c_exp   = 8'h11;
        c_out   = 8'h22;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i % 2 == 0) begin
                check("z_ready_chk", 32'(c_ready), 32'd0);
                c_out = 8'h11;
            end else begin
                check("z_ready_idle", 32'(c_ready), 32'd1);
                check("z_pass", 32'(c_pass), 32'((i + 1) / 2));
                c_out = 8'h22;
            end
        end
        c_valid = 1'b0;
        check("z_fail", 32'(c_fail), 32'd0);
        check("z_ffv", 32'(c_ffv), 32'd0);
        check("z_done", 32'(c_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dp_result_checker.md
DP_RESULT_CHECKER -- requirements
Module: dp_result_checker

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL set the width of the compared datapath result.
REQ-002 Parameter SETTLE_CYCLES, default 2, range 0..15, SHALL set the idle cycles between vector acceptance and result sampling.
REQ-003 Parameter CNTW, default 8, SHALL set the width of the pass/fail counters and the vector index.
REQ-004 The block has one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 vec_valid  in  1  expected-result vector present.
REQ-008 vec_ready  out  1  checker can accept a vector.
REQ-009 vec_exp  in  DATAWIDTH  expected result for the current vector.
REQ-010 vec_last  in  1  marks the final vector of a run.
REQ-011 dut_out  in  DATAWIDTH  datapath component output under check.
REQ-012 pass_cnt  out  CNTW  number of matching vectors.
REQ-013 fail_cnt  out  CNTW  number of mismatching vectors.
REQ-014 first_fail_idx  out  CNTW  0-based index of the first mismatching vector.
REQ-015 first_fail_vld  out  1  first_fail_idx holds a valid index.
REQ-016 mismatch  out  1  one-cycle pulse per mismatching vector.
REQ-017 done  out  1  run complete; held high.

Function
REQ-018 The FSM SHALL have four states: IDLE, SETTLE, CHECK and DONE.
REQ-019 vec_ready SHALL be 1 only in IDLE; it is combinational from state.
REQ-020 A vector is accepted when vec_valid & vec_ready on a clock edge; vec_exp and vec_last SHALL be latched on that edge.
REQ-021 On acceptance, the FSM SHALL go to SETTLE and load the settle counter with SETTLE_CYCLES; if SETTLE_CYCLES = 0 it SHALL go directly to CHECK.
REQ-022 SETTLE SHALL decrement the counter each cycle and go to CHECK on the cycle the counter reaches 0, giving exactly SETTLE_CYCLES cycles in SETTLE.
REQ-023 In CHECK, dut_out SHALL be compared against the latched expected value with a full DATAWIDTH equality compare.
REQ-024 On a match, pass_cnt SHALL increment at the CHECK edge.
REQ-025 On a mismatch, fail_cnt SHALL increment and mismatch SHALL be 1 in the following cycle only.
REQ-026 On the first mismatch since reset, first_fail_idx SHALL capture the vector index and first_fail_vld SHALL be set; later mismatches SHALL NOT overwrite either.
REQ-027 The vector index SHALL increment after every CHECK.
REQ-028 pass_cnt, fail_cnt and the vector index SHALL saturate at 2^CNTW-1 and never wrap.
REQ-029 After CHECK, the FSM SHALL go to DONE if the latched last flag is 1, otherwise to IDLE.
REQ-030 Latency: for acceptance at edge T, the compare SHALL occur at edge T+1+SETTLE_CYCLES and mismatch SHALL be high in the cycle after that edge.
REQ-031 In DONE, done SHALL be 1 and vec_ready SHALL be 0; vec_valid SHALL be ignored; the block SHALL stay in DONE until rst.
REQ-032 Changes on dut_out outside CHECK SHALL have no effect.

Reset
REQ-033 When rst is 1 at a clock edge, state SHALL become IDLE and pass_cnt, fail_cnt, the vector index, first_fail_idx, first_fail_vld, mismatch and done SHALL all become 0.
REQ-034 Reset SHALL override any simultaneous acceptance, and a vector in SETTLE or CHECK SHALL be discarded without being counted.
REQ-035 vec_ready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.

Structure
REQ-036 The state encoding (IDLE=0, SETTLE=1, CHECK=2, DONE=3) and the default DATAWIDTH and CNTW constants SHALL reside in the shared package dp_pkg.
REQ-037 The saturating counter SHALL be a sub-module, dp_sat_counter (parameter width; inputs clk, rst, inc; output count), instantiated three times.

Verification
REQ-038 SETTLE_CYCLES=2: after reset, send vec_exp=3 with dut_out=3 (ADD 1+2) -> pass_cnt=1 and fail_cnt=0 at acceptance+3 edges, with no mismatch pulse.
REQ-039 Send vec_exp=2 with dut_out=1 (DIV 6/3, faulty) as vector 0 -> fail_cnt=1, a single-cycle mismatch pulse, first_fail_idx=0 and first_fail_vld=1.
REQ-040 Send 4 vectors in which vectors 1 and 3 mismatch, with vec_last on vector 3 -> pass=2, fail=2, first_fail_idx=1, done=1, and vec_ready=0 thereafter.
REQ-041 Assert rst during SETTLE of vector 0 -> all counters stay 0, state returns to IDLE, and the next vector is index 0.
REQ-042 With CNTW=2, send 5 matching vectors -> pass_cnt saturates at 3.
REQ-043 With SETTLE_CYCLES=0 and vec_valid held high -> one vector is accepted every 2 cycles, and dut_out is sampled on the edge after acceptance.
